// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } ifq_entry_t;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// In-order entry FIFO for fetched {pc, word} pairs; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  ifq_entry_t    entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output ifq_entry_t    head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);
  ifq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer/occupancy next state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage and pointer registers; storage clears on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
    (pop_i && !flush_i) |-> !empty_o) else $fatal(1, "ifetch_fifo: pop from empty queue");
endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited memory requests,
// in-order response queue, redirect flush with in-flight discard.
// Optional IFETCH_PERF_EN adds stall / flush performance counters.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [XLEN-1:0] ins,
  output logic [XLEN-1:0] ins_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_flush_count
`endif
);
  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_aligned;
  logic [CW-1:0]   outst_q, outst_d, disc_q, disc_d, count;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_fire, push, pop, empty, full;
  ifq_entry_t      head, entry;

  // Every in-flight request reserves a queue slot, so responses can never overflow.
  assign credit_used   = {1'b0, outst_q} + {1'b0, count};
  assign mem_req_valid = !rst && (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rsp_fire      = mem_rsp_valid;
  assign redir_aligned = redirect_pc & ~XLEN'(3);

  // A response arriving in a redirect cycle is stale and is dropped by the flush.
  assign push  = rsp_fire && (disc_q == '0) && !redirect_valid;
  assign pop   = ins_valid && ins_ready && !redirect_valid;
  assign entry = '{pc: rsp_pc_q, word: mem_rsp_data};

  // PC, credit and discard next state; redirect overrides the normal updates.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect_valid) begin
      fetch_pc_d = redir_aligned;
      rsp_pc_d   = redir_aligned;
      disc_d     = outst_d;  // everything still owed by memory is now stale
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (rsp_fire) begin
        if (disc_q != '0) disc_d   = disc_q - 1'b1;
        else              rsp_pc_d = rsp_pc_q + PC_INC;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign ins_valid = !empty;
  assign ins       = head.word;
  assign ins_pc    = head.pc;

  a_rsp_owed: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> (outst_q != '0)) else $fatal(1, "ifetch_queue: response with nothing outstanding");
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> !full) else $fatal(1, "ifetch_queue: push into full queue");

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_q, flush_q;

  // Saturating counters: decode-starved cycles and redirect events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (ins_ready && !ins_valid && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (redirect_valid && (flush_q != '1))          flush_q <= flush_q + 1'b1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_flush_count  = flush_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed scenarios push expected
// instructions / request addresses; a negedge monitor pops and compares.
module tb_ifetch_queue;
  localparam logic [31:0] KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins, ins_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .ins_pc         (ins_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus-owned knobs
  logic        mem_rdy  = 1'b0;
  int          lat      = 1;
  int          rd_grant = 0;
  bit          strict_req = 1'b0;
  int          end_req  = 0;
  int          nredir   = 0;
  logic [31:0] exp_pc  [128];
  int          exp_cyc [128];
  int          exp_wr   = 0;
  logic [31:0] exp_ra  [128];
  int          exp_ra_wr = 0;

  // monitor-owned state
  int          exp_rd = 0, exp_ra_rd = 0, rd_taken = 0, end_seen = 0;
  int          n_cmp = 0, n_bad = 0;
  bit          redir_prev = 1'b0;
  logic [31:0] pend_a[$];
  int          pend_due[$];

  assign mem_req_ready = mem_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model plus scoreboard monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    ins_ready = (rd_taken < rd_grant);
    if (rst) begin
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
      chk("rst_ins", ins, 32'd0);
      chk("rst_ins_pc", ins_pc, 32'd0);
      pend_a.delete();
      pend_due.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if (redir_prev) chk("ins_valid_after_redirect", {31'b0, ins_valid}, 32'd0);
      if (ins_valid && ins_ready) begin
        if (exp_rd >= exp_wr) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ins: got pc %h, none expected", ins_pc);
        end else begin
          chk("ins_pc", ins_pc, exp_pc[exp_rd]);
          chk("ins_word", ins, exp_pc[exp_rd] ^ KEY);
          if (exp_cyc[exp_rd] >= 0) chk("ins_cycle", cyc, exp_cyc[exp_rd]);
          exp_rd++;
        end
        rd_taken++;
      end
      // response presented this cycle (in request order)
      if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_a.pop_front() ^ KEY;
        void'(pend_due.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_ra_rd < exp_ra_wr) begin
          chk("req_addr", mem_req_addr, exp_ra[exp_ra_rd]);
          exp_ra_rd++;
        end
        pend_a.push_back(mem_req_addr);
        pend_due.push_back(cyc + lat);
      end else if (strict_req && exp_ra_rd == exp_ra_wr) begin
        chk("req_held_low", {31'b0, mem_req_valid}, 32'd0);
      end
    end
    redir_prev = redirect_valid && !rst;
    if (end_req != end_seen) begin
      chk("drained", exp_rd, exp_wr);
`ifdef IFETCH_PERF_EN
      chk("perf_flush_count", perf_flush_count, nredir);
`endif
      end_seen = end_req;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Returns the cycle index of the first post-reset negedge.
  task automatic do_reset(input int l, input logic rdy, output int r);
    rst = 1'b1;
    redirect_valid = 1'b0;
    mem_rdy = 1'b0;
    strict_req = 1'b0;
    tick(3);
    rd_grant = rd_taken;
    nredir = 0;
    lat = l;
    mem_rdy = rdy;
    rst = 1'b0;
    r = cyc;
  endtask

  task automatic exp_ins(input logic [31:0] pc, input int c);
    exp_pc[exp_wr] = pc;
    exp_cyc[exp_wr] = c;
    exp_wr++;
  endtask

  task automatic exp_req(input logic [31:0] a);
    exp_ra[exp_ra_wr] = a;
    exp_ra_wr++;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    nredir++;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_rd != exp_wr && n < 300) begin
      tick();
      n++;
    end
    end_req++;
    tick(2);
  endtask

  initial begin
    int r, n;
    // 1: streaming at latency 1, one instruction per cycle from request+2
    do_reset(1, 1'b1, r);
    for (int i = 0; i < 8; i++) begin
      exp_req(32'(i * 4));
      exp_ins(32'(i * 4), r + 2 + i);
    end
    rd_grant = rd_taken + 8;
    wait_drain();

    // 2: decode stalled: exactly 4 requests, then drain in order
    do_reset(1, 1'b1, r);
    strict_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_req(32'(i * 4));
    tick(12);
    strict_req = 1'b0;
    for (int i = 0; i < 4; i++) exp_ins(32'(i * 4), -1);
    rd_grant = rd_taken + 4;
    wait_drain();

    // 3: redirect with 3 outstanding; low address bits ignored
    do_reset(6, 1'b1, r);
    n = 0;
    while (pend_a.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    mem_rdy = 1'b0;
    tick();
    redirect(32'h0000_0103);
    exp_req(32'h0000_0100);
    mem_rdy = 1'b1;
    for (int i = 0; i < 6; i++) exp_ins(32'h100 + 32'(i * 4), -1);
    rd_grant = rd_taken + 6;
    wait_drain();

    // 4: redirect coinciding with a request fire and a response
    do_reset(1, 1'b1, r);
    tick();
    redirect(32'h0000_0040);
    exp_req(32'h0000_0040);
    for (int i = 0; i < 6; i++) exp_ins(32'h40 + 32'(i * 4), -1);
    rd_grant = rd_taken + 6;
    wait_drain();

    // 5: back-to-back redirects with a filled queue and responses in flight
    do_reset(3, 1'b1, r);
    tick(4);
    redirect(32'h0000_0200);
    redirect(32'h0000_0300);
    for (int i = 0; i < 6; i++) exp_ins(32'h300 + 32'(i * 4), -1);
    rd_grant = rd_taken + 6;
    wait_drain();

    // 6: fetch PC wraps past the top of the address space
    do_reset(1, 1'b0, r);
    tick(2);
    redirect(32'hFFFF_FFFA);
    exp_req(32'hFFFF_FFF8);
    exp_req(32'hFFFF_FFFC);
    exp_req(32'h0000_0000);
    exp_req(32'h0000_0004);
    exp_ins(32'hFFFF_FFF8, -1);
    exp_ins(32'hFFFF_FFFC, -1);
    exp_ins(32'h0000_0000, -1);
    exp_ins(32'h0000_0004, -1);
    mem_rdy = 1'b1;
    rd_grant = rd_taken + 4;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
